// File: rtl/div_unit_pkg.sv
// Shared types and constants for the multi-cycle divider: state encoding,
// bus widths, handshake levels and the conditional two's-complement helper.
package div_unit_pkg;

    localparam int REG_BUS        = 32;
    localparam int DOUBLE_REG_BUS = 64;

    localparam logic DIV_START           = 1'b1;
    localparam logic DIV_STOP            = 1'b0;
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

    // Index of the final restoring step; one quotient bit per step.
    localparam logic [4:0] LAST_STEP = 5'd31;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_t;

    function automatic logic [REG_BUS-1:0] negate_if(input logic [REG_BUS-1:0] value,
                                                     input logic neg);
        return neg ? (~value + 32'd1) : value;
    endfunction

endpackage

// File: rtl/div_unit.sv
// Multi-cycle 32-bit restoring divider serving the execute stage's divide
// handshake; returns {remainder, quotient} with a ready flag.
module div_unit
    import div_unit_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      signed_div_i,
    input  logic [REG_BUS-1:0]        opdata1_i,
    input  logic [REG_BUS-1:0]        opdata2_i,
    input  logic                      start_i,
    input  logic                      annul_i,
    output logic [DOUBLE_REG_BUS-1:0] result_o,
    output logic                      ready_o
);

    div_state_t state_q;
    div_state_t state_next;

    logic [4:0]                cnt_q;
    logic [64:0]               work_q;
    logic [REG_BUS-1:0]        divisor_q;
    logic                      signed_q;
    logic                      dividend_neg_q;
    logic                      divisor_neg_q;
    logic [DOUBLE_REG_BUS-1:0] final_q;

    logic                      dividend_neg;
    logic                      divisor_neg;
    logic [33:0]               rem_shift;
    logic                      rem_ge;
    logic [32:0]               rem_diff;
    logic [64:0]               step_work;
    logic [REG_BUS-1:0]        quo_fixed;
    logic [REG_BUS-1:0]        rem_fixed;

    assign dividend_neg = signed_div_i & opdata1_i[31];
    assign divisor_neg  = signed_div_i & opdata2_i[31];

    // One restoring step: shift left, trial-subtract, keep the difference
    // when it did not go negative. rem stays below the divisor, so the low
    // 33 bits of the difference are exact whenever rem_ge holds.
    always_comb begin
        rem_shift = work_q[64:31];
        rem_ge    = rem_shift >= {2'b00, divisor_q};
        rem_diff  = rem_shift[32:0] - {1'b0, divisor_q};
        step_work = {rem_ge ? rem_diff : rem_shift[32:0], work_q[30:0], rem_ge};
        quo_fixed = negate_if(step_work[31:0], signed_q & (dividend_neg_q ^ divisor_neg_q));
        rem_fixed = negate_if(step_work[63:32], signed_q & dividend_neg_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DivFree;
        end else begin
            state_q <= state_next;
        end
    end

    always_comb begin
        state_next = state_q;
        if (annul_i) begin
            state_next = DivFree;
        end else begin
            case (state_q)
                DivFree: begin
                    if (start_i == DIV_START) begin
                        state_next = (opdata2_i == '0) ? DivByZero : DivOn;
                    end
                end
                DivByZero: state_next = DivEnd;
                DivOn: begin
                    if (cnt_q == LAST_STEP) begin
                        state_next = DivEnd;
                    end
                end
                DivEnd: begin
                    if (start_i == DIV_STOP) begin
                        state_next = DivFree;
                    end
                end
                default: state_next = DivFree;
            endcase
        end
    end

    // NOTE: only control state and the outputs are reset; the operand and
    // working registers are always reloaded on acceptance before being read.
    always_ff @(posedge clk) begin
        if (rst || annul_i) begin
            cnt_q    <= '0;
            ready_o  <= DIV_RESULT_NOT_READY;
            result_o <= '0;
        end else begin
            case (state_q)
                DivFree: begin
                    ready_o  <= DIV_RESULT_NOT_READY;
                    result_o <= '0;
                    if (start_i == DIV_START) begin
                        cnt_q          <= '0;
                        signed_q       <= signed_div_i;
                        dividend_neg_q <= dividend_neg;
                        divisor_neg_q  <= divisor_neg;
                        divisor_q      <= negate_if(opdata2_i, divisor_neg);
                        work_q         <= {33'd0, negate_if(opdata1_i, dividend_neg)};
                    end
                end
                DivByZero: begin
                    final_q <= '0;
                end
                DivOn: begin
                    work_q <= step_work;
                    cnt_q  <= cnt_q + 5'd1;
                    if (cnt_q == LAST_STEP) begin
                        final_q <= {rem_fixed, quo_fixed};
                    end
                end
                DivEnd: begin
                    if (start_i == DIV_START) begin
                        ready_o  <= DIV_RESULT_READY;
                        result_o <= final_q;
                    end else begin
                        ready_o  <= DIV_RESULT_NOT_READY;
                        result_o <= '0;
                    end
                end
                default: begin
                    ready_o  <= DIV_RESULT_NOT_READY;
                    result_o <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider that answers the execute stage's divide request handshake. It samples `div_opdata1`/`div_opdata2`/`signed_div` on `div_start` and iterates one quotient bit per cycle. It then returns a 64-bit {remainder, quotient} with a ready flag. The execute stage routes that result to HI/LO and releases its stall request. It sits beside the execute stage and is fed directly by its divide outputs.

## Interface
- No parameters; widths fixed by `RegBus` (32) and `DoubleRegBus` (64) in defines.v.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset (`RstEnable`).
- `signed_div_i`  in  1  1 = DIV (two's complement), 0 = DIVU.
- `opdata1_i`  in  32  dividend.
- `opdata2_i`  in  32  divisor.
- `start_i`  in  1  request; held high by execute stage until result consumed.
- `annul_i`  in  1  cancel (exception/flush); overrides `start_i`.
- `result_o`  out  64  [63:32] remainder (to HI), [31:0] quotient (to LO).
- `ready_o`  out  1  result valid (`DivResultReady`).

## Operation
- Behaviour is defined by four states: `DivFree`, `DivByZero`, `DivOn` and `DivEnd`.
- **DivFree**
  - If `start_i`=1 and `annul_i`=0, latch operands and sign mode.
  - If divisor = 0, go to `DivByZero`.
  - Otherwise go to `DivOn` with cnt = 0.
  - In signed mode, latched magnitudes are absolute values; abs(0x80000000) = 0x80000000 as unsigned.
- **DivOn** performs one restoring step per cycle on a 65-bit working register {rem[32:0], quo[31:0]}:
  - Shift the register left 1.
  - Compute trial = rem − divisor.
  - If trial ≥ 0, set rem = trial and quo LSB = 1; otherwise set LSB = 0.
  - Increment cnt. After the step with cnt = 31, go to `DivEnd`.
- **Sign fix** on entry to `DivEnd` (signed mode only):
  - Negate the quotient if the dividend sign ≠ divisor sign.
  - Negate the remainder if the dividend was negative.
  - Unsigned mode uses the raw values.
- **DivByZero**: result = 0, then go to `DivEnd` (architecturally UNPREDICTABLE; fixed to 0).
- **DivEnd**:
  - `ready_o`=1 and `result_o` = final value.
  - Stay in `DivEnd` while `start_i`=1.
  - When `start_i`=0, go to `DivFree`; `ready_o`=0 and `result_o`=0 from the next cycle.
- **Annul**: `annul_i`=1 in any state forces `DivFree` next cycle with `ready_o`=0 and `result_o`=0; no result is produced.
- **Operand changes**: changes on `opdata*_i`/`signed_div_i` after acceptance are ignored until the next acceptance in `DivFree`.
- **`start_i` drop**: if `start_i` falls during `DivOn` without `annul_i`, the computation completes, then returns to `DivFree` one cycle after `DivEnd`.

## Timing
- Reset values: state = `DivFree`, cnt = 0, `ready_o`=0, `result_o`=0. Reset mid-operation aborts the operation identically to annul.
- Outputs are registered; there is no combinational path from inputs to outputs.
- Normal latency, with start sampled in `DivFree` at edge n:
  - `DivOn` runs during cycles n+1 … n+32.
  - `ready_o` rises at n+33, i.e. 33 cycles after acceptance.
- Divide-by-zero latency: `DivByZero` at n+1, `ready_o` at n+2.
- Back-to-back operation: the minimum gap is one `DivFree` cycle, because `start_i` must be seen low in `DivEnd`.
- Priority order is `rst` > `annul_i` > state transitions.

## Structure
- defines.v holds:
  - state encodings `DivFree`/`DivByZero`/`DivOn`/`DivEnd` (2 bits);
  - handshake constants `DivStart`/`DivStop` and `DivResultReady`/`DivResultNotReady`;
  - the existing `RegBus`/`DoubleRegBus` widths.
- This is a single module with no sub-module. The optional negate helper is inline; a separate `div_abs` is not warranted.
- Estimated size: ~150–200 lines.

## Test plan
- Unsigned 100/7, start held high → `ready_o` at n+33, `result_o` = 0x00000002_0000000E; drop start → `ready_o`=0 next cycle.
- Signed −7/2 (0xFFFFFFF9/0x00000002) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7/−2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- Signed 0x80000000/0xFFFFFFFF → quotient 0x80000000, remainder 0. Unsigned 0xFFFFFFFF/0x00000001 → quotient 0xFFFFFFFF, remainder 0.
- Divide by zero: 5/0 → `ready_o` at n+2, `result_o` = 0.
- Annul at n+10 → state `DivFree` at n+11, `ready_o` never asserts. New 9/3 started at n+12 → result 0x00000000_00000003 at n+45.
- `rst` asserted at n+20 of a divide → all outputs zero next cycle. Operands changed after acceptance → result reflects the latched operands only.
